// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared memory-side constants, opcodes and responder state encoding
package riscv_mem_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam int         RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ram_state_t;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - single-port synchronous data RAM with registered read
module ram_array
  import riscv_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [RAM_DATA_W-1:0] wdata,
  output logic [RAM_DATA_W-1:0] rdata
);

  logic [RAM_DATA_W-1:0] mem [2**ADDR_WIDTH];
  logic [RAM_DATA_W-1:0] rdata_q;

  // Write port and read-before-write registered read, no reset on storage
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - wait-stated data RAM responder with range/alignment check
module data_ram_responder
  import riscv_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  i_RAM_CE,
  input  logic                  i_RAM_RD,
  input  logic                  i_RAM_WR,
  input  logic [31:0]           i_RAM_ADDR,
  input  logic [RAM_DATA_W-1:0] i_RAM_DATA_WR,
  output logic [RAM_DATA_W-1:0] o_RAM_DATA_RD,
  output logic                  o_RAM_ACK,
  output logic                  o_RAM_BUSY,
  output logic                  o_RAM_ERR
);

  ram_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [RAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [RAM_DATA_W-1:0] rdata_q, rdata_d;

  logic [31:0]           offset;
  logic                  bad_addr;
  logic                  accept;
  logic                  enter_resp;
  logic                  ram_we;
  logic [RAM_DATA_W-1:0] ram_rdata;
  logic                  rd_ok;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range
  assign offset   = i_RAM_ADDR - BASE_ADDR;
  assign bad_addr = (i_RAM_ADDR[1:0] != 2'b00) || ((offset >> (ADDR_WIDTH + 2)) != 32'd0);
  assign accept   = (state_q == IDLE) && i_RAM_CE && (i_RAM_RD || i_RAM_WR);

  // Next-state, wait counter and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = i_RAM_WR;
          rd_d    = i_RAM_RD && !i_RAM_WR;
          err_d   = bad_addr;
          widx_d  = offset[ADDR_WIDTH+1:2];
          wdata_d = i_RAM_DATA_WR;
          cnt_d   = 4'(WAIT_STATES - 1);
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (rd_q && !err_q) begin
          rdata_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM edge coincides with the edge that enters RESP, so it uses the _d view
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign ram_we     = enter_resp && wr_d && !err_d;

  ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (widx_d),
    .wdata (wdata_d),
    .rdata (ram_rdata)
  );

  // Control and captured-request registers; async abort drops any pending write
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Fresh RAM word is shown during the read ACK, then held in rdata_q
  assign rd_ok         = (state_q == RESP) && rd_q && !err_q;
  assign o_RAM_DATA_RD = rd_ok ? ram_rdata : rdata_q;
  assign o_RAM_ACK     = (state_q == RESP);
  assign o_RAM_BUSY    = (state_q != IDLE);
  assign o_RAM_ERR     = (state_q == RESP) && err_q;

endmodule
